// File: rtl/detector_jogada_if.sv
// Button-side bus of the play detector: raw buttons and enable in,
// accepted-play pulse, code and debug status out.
interface detector_jogada_if;
  logic       habilita;
  logic [3:0] botoes;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       jogada_invalida;
  logic       db_tem_jogada;
  logic [2:0] db_estado;

  modport master (
    output habilita, botoes,
    input  jogada_feita, jogada, jogada_invalida, db_tem_jogada, db_estado
  );

  modport slave (
    input  habilita, botoes,
    output jogada_feita, jogada, jogada_invalida, db_tem_jogada, db_estado
  );
endinterface

// File: rtl/detector_jogada.sv
// Synchronizes and debounces four raw buttons; emits one pulse per stable
// one-hot press and flags multi-button presses.
//
// state         | meaning
// OCIOSO        | no button seen, waiting for a press
// CONTANDO      | counting identical samples of the candidate pattern
// VALIDA        | one cycle: pulse jogada_feita or jogada_invalida
// ESPERA_SOLTAR | waiting for a debounced release
module detector_jogada #(
  parameter int N_DEBOUNCE = 5
) (
  input logic              clock,
  input logic              reset,
  detector_jogada_if.slave bus
);
  localparam int CW = $clog2(N_DEBOUNCE) + 1;
  localparam logic [CW-1:0] CNT_FIM = CW'(N_DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_UM  = CW'(1);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    CONTANDO      = 3'd1,
    VALIDA        = 3'd2,
    ESPERA_SOLTAR = 3'd3
  } estado_t;

  estado_t       estado, estado_prox;
  logic [3:0]    s1, s2;
  logic [3:0]    cand, cand_prox;
  logic [CW-1:0] cnt, cnt_prox;
  logic [3:0]    jogada_r, jogada_prox;
  logic          cand_um_quente;

  assign cand_um_quente = (cand != 4'd0) && ((cand & (cand - 4'd1)) == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1       <= 4'd0;
      s2       <= 4'd0;
      estado   <= OCIOSO;
      cand     <= 4'd0;
      cnt      <= '0;
      jogada_r <= 4'd0;
    end else begin
      s1       <= bus.botoes;
      s2       <= s1;
      estado   <= estado_prox;
      cand     <= cand_prox;
      cnt      <= cnt_prox;
      jogada_r <= jogada_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    cand_prox   = cand;
    cnt_prox    = cnt;
    jogada_prox = jogada_r;
    case (estado)
      OCIOSO: begin
        if (s2 != 4'd0) begin
          if (bus.habilita) begin
            estado_prox = CONTANDO;
            cand_prox   = s2;
            cnt_prox    = CNT_UM;
          end else begin
            estado_prox = ESPERA_SOLTAR;
            cnt_prox    = '0;
          end
        end
      end
      CONTANDO: begin
        if (!bus.habilita) begin
          estado_prox = ESPERA_SOLTAR;
          cnt_prox    = '0;
        end else if (s2 == 4'd0) begin
          estado_prox = OCIOSO;
          cnt_prox    = '0;
        end else if (s2 != cand) begin
          // a bounce to another pattern restarts the count on the new one
          cand_prox = s2;
          cnt_prox  = CNT_UM;
        end else if (cnt == CNT_FIM) begin
          estado_prox = VALIDA;
          cnt_prox    = '0;
          if (cand_um_quente) jogada_prox = cand;
        end else begin
          cnt_prox = cnt + CNT_UM;
        end
      end
      VALIDA: begin
        estado_prox = ESPERA_SOLTAR;
        cnt_prox    = '0;
      end
      ESPERA_SOLTAR: begin
        if (s2 != 4'd0) begin
          cnt_prox = '0;
        end else if (cnt == CNT_FIM) begin
          estado_prox = OCIOSO;
          cnt_prox    = '0;
        end else begin
          cnt_prox = cnt + CNT_UM;
        end
      end
      default: begin
        estado_prox = OCIOSO;
        cnt_prox    = '0;
      end
    endcase
  end

  assign bus.jogada_feita    = (estado == VALIDA) && cand_um_quente;
  assign bus.jogada_invalida = (estado == VALIDA) && !cand_um_quente;
  assign bus.jogada          = jogada_r;
  assign bus.db_tem_jogada   = (s2 != 4'd0);
  assign bus.db_estado       = estado;
endmodule

// File: tb/tb_detector_jogada.sv
// Directed stimulus for detector_jogada; a scoreboard queue holds expected
// pulses and a negedge monitor checks each pulse the DUT presents.
module tb_detector_jogada;
  logic clock = 1'b0;
  logic reset;

  detector_jogada_if dj_if ();

  detector_jogada #(.N_DEBOUNCE(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dj_if.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       inv;
    logic [3:0] code;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] modelo_jogada = 4'd0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nome, got, req);
    end
  endtask

  task automatic espera_jogada(input logic [3:0] code);
    exp_t e;
    e.inv = 1'b0;
    e.code = code;
    modelo_jogada = code;
    q.push_back(e);
  endtask

  task automatic espera_invalida();
    exp_t e;
    e.inv = 1'b1;
    e.code = modelo_jogada;
    q.push_back(e);
  endtask

  task automatic press(input logic [3:0] p, input int on_c, input int off_c);
    @(negedge clock);
    dj_if.botoes = p;
    repeat (on_c) @(negedge clock);
    dj_if.botoes = 4'd0;
    repeat (off_c) @(negedge clock);
  endtask

  // monitor: every pulse must match the oldest pending expectation
  always @(negedge clock) begin
    if (!reset && (dj_if.jogada_feita || dj_if.jogada_invalida)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {dj_if.jogada_feita, dj_if.jogada_invalida}, 2'b00);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", {dj_if.jogada_feita, dj_if.jogada_invalida},
            e.inv ? 2'b01 : 2'b10);
        chk("pulse_jogada", dj_if.jogada, e.code);
      end
    end
  end

  logic [3:0] seq_tab [16] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000,
                               4'b0010, 4'b0001, 4'b1000, 4'b0100,
                               4'b1000, 4'b0010, 4'b0100, 4'b0001,
                               4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    logic [2:0]  seq_est[$];
    logic [14:0] pk;

    reset = 1'b1;
    dj_if.habilita = 1'b0;
    dj_if.botoes   = 4'd0;
    repeat (3) @(negedge clock);
    chk("rst_jogada_feita", dj_if.jogada_feita, 1'b0);
    chk("rst_jogada_invalida", dj_if.jogada_invalida, 1'b0);
    chk("rst_jogada", dj_if.jogada, 4'd0);
    chk("rst_db_tem_jogada", dj_if.db_tem_jogada, 1'b0);
    chk("rst_db_estado", dj_if.db_estado, 3'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("idle_db_estado", dj_if.db_estado, 3'd0);

    // first press: latency and state walk
    dj_if.habilita = 1'b1;
    espera_jogada(4'b0010);
    @(negedge clock);
    dj_if.botoes = 4'b0010;
    seq_est.push_back(3'd0);
    for (int k = 0; k < 22; k++) begin
      @(posedge clock);
      #1;
      if (k == 0) chk("tem_jogada_e0", dj_if.db_tem_jogada, 1'b0);
      if (k == 1) chk("tem_jogada_e1", dj_if.db_tem_jogada, 1'b1);
      if (k == 5) chk("pulse_not_before_e6", dj_if.jogada_feita, 1'b0);
      if (k == 6) begin
        chk("pulse_at_e6", dj_if.jogada_feita, 1'b1);
        chk("jogada_at_e6", dj_if.jogada, 4'b0010);
      end
      if (k == 7) chk("pulse_one_cycle", dj_if.jogada_feita, 1'b0);
      if (dj_if.db_estado != seq_est[$]) seq_est.push_back(dj_if.db_estado);
      if (k == 9) dj_if.botoes = 4'd0;
    end
    chk("estado_seq_len", seq_est.size(), 5);
    pk = '0;
    foreach (seq_est[i]) if (i < 5) pk = {pk[11:0], seq_est[i]};
    chk("estado_seq", pk, {3'd0, 3'd1, 3'd2, 3'd3, 3'd0});
    chk("jogada_held", dj_if.jogada, 4'b0010);

    // short press rejected
    press(4'b0100, 3, 10);
    chk("short_db_estado", dj_if.db_estado, 3'd0);
    chk("short_jogada", dj_if.jogada, 4'b0010);

    // bouncing press then stable hold
    espera_jogada(4'b0001);
    press(4'b0001, 2, 2);
    press(4'b0001, 2, 2);
    press(4'b0001, 10, 10);
    chk("bounce_jogada", dj_if.jogada, 4'b0001);

    // multi-button press
    espera_invalida();
    press(4'b0011, 10, 10);
    chk("invalid_jogada", dj_if.jogada, 4'b0001);

    // press swallowed while disabled, even after enable rises mid-press
    dj_if.habilita = 1'b0;
    @(negedge clock);
    dj_if.botoes = 4'b1000;
    repeat (3) @(negedge clock);
    dj_if.habilita = 1'b1;
    repeat (2) @(negedge clock);
    dj_if.botoes = 4'd0;
    repeat (10) @(negedge clock);
    chk("swallow_jogada", dj_if.jogada, 4'b0001);
    espera_jogada(4'b1000);
    press(4'b1000, 10, 10);
    chk("after_swallow_jogada", dj_if.jogada, 4'b1000);

    // reset in the middle of CONTANDO
    @(negedge clock);
    dj_if.botoes = 4'b0100;
    repeat (4) @(negedge clock);
    chk("mid_contando", dj_if.db_estado, 3'd1);
    reset = 1'b1;
    dj_if.botoes = 4'd0;
    @(negedge clock);
    chk("rst_mid_estado", dj_if.db_estado, 3'd0);
    chk("rst_mid_jogada", dj_if.jogada, 4'd0);
    chk("rst_mid_pulse", dj_if.jogada_feita, 1'b0);
    reset = 1'b0;
    modelo_jogada = 4'd0;
    repeat (10) @(negedge clock);

    // full 16-round game
    for (int r = 1; r <= 16; r++) begin
      for (int i = 0; i < r; i++) begin
        espera_jogada(seq_tab[i]);
        press(seq_tab[i], 10, 10);
      end
      if (r < 16) begin
        espera_jogada(seq_tab[r]);
        press(seq_tab[r], 10, 10);
      end
    end
    chk("game_final_jogada", dj_if.jogada, seq_tab[15]);

    repeat (5) @(negedge clock);
    chk("missing_pulses", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
